// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
package aes_ctrl_pkg;

    localparam int AES128_ROUNDS = 10;
    localparam int RND_W         = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: key-load pulse, per-round rcon enables,
// round index and completion pulse for the round datapath.
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS   = AES128_ROUNDS,
    parameter int ROUND_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             abort,
    input  logic             dp_stall,
    output logic             kld,
    output logic             rcon_en,
    output logic [RND_W-1:0] round,
    output logic             first_round,
    output logic             last_round,
    output logic             busy,
    output logic             done
);

    localparam int              CYC_W    = 3;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(ROUND_CYCLES - 1);
    localparam logic [RND_W-1:0] RND_LAST = RND_W'(NUM_ROUNDS);

    if (NUM_ROUNDS < 2 || NUM_ROUNDS > 15) begin : g_bad_rounds
        $error("aes_round_ctrl: NUM_ROUNDS must be 2..15");
    end
    if (ROUND_CYCLES < 1 || ROUND_CYCLES > 8) begin : g_bad_cycles
        $error("aes_round_ctrl: ROUND_CYCLES must be 1..8");
    end

    ctrl_state_e      r_state;
    logic [RND_W-1:0] r_round;
    logic [CYC_W-1:0] r_cyc;

    logic w_hs;
    logic w_end_rnd;
    logic w_last;

    assign w_last    = (r_round == RND_LAST);
    assign w_end_rnd = (r_state == ST_ROUND) && (r_cyc == CYC_LAST)
                       && !dp_stall;
    assign w_hs      = start_valid && start_ready;

    // abort suppresses every pulse in the cycle it is raised
    assign start_ready = (r_state == ST_IDLE) && !abort;
    assign kld         = (r_state == ST_LOAD) && !abort;
    assign done        = (r_state == ST_DONE) && !abort;
    assign rcon_en     = w_end_rnd && !w_last && !abort;
    assign busy        = (r_state != ST_IDLE);
    assign round       = r_round;
    assign first_round = (r_state == ST_ROUND) && (r_round == RND_W'(1));
    assign last_round  = (r_state == ST_ROUND) && w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_round <= '0;
            r_cyc   <= '0;
        end else if (abort && r_state != ST_IDLE) begin
            r_state <= ST_IDLE;
            r_round <= '0;
            r_cyc   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_state <= ST_LOAD;
                        r_round <= '0;
                        r_cyc   <= '0;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_ROUND;
                    r_round <= RND_W'(1);
                    r_cyc   <= '0;
                end
                ST_ROUND: begin
                    if (w_end_rnd) begin
                        r_cyc <= '0;
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_round <= r_round + 1'b1;
                        end
                    end else if (!dp_stall) begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_round <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_round <= '0;
                    r_cyc   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: scenario table with an event
// scoreboard, plus hand sequences for flags, abort, held start and reset.
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_valid = 1'b0;
    logic abort = 1'b0;
    logic dp_stall = 1'b0;
    int   sel = 0;

    logic       sv_a, sr_a, kl_a, rc_a, fr_a, lr_a, bs_a, dn_a;
    logic       sv_b, sr_b, kl_b, rc_b, fr_b, lr_b, bs_b, dn_b;
    logic [3:0] rd_a, rd_b;

    always #5 clk = ~clk;

    assign sv_a = start_valid && (sel == 0);
    assign sv_b = start_valid && (sel == 1);

    aes_round_ctrl u_a (
        .clk(clk), .rst_n(rst_n), .start_valid(sv_a), .start_ready(sr_a),
        .abort(abort), .dp_stall(dp_stall), .kld(kl_a), .rcon_en(rc_a),
        .round(rd_a), .first_round(fr_a), .last_round(lr_a),
        .busy(bs_a), .done(dn_a)
    );

    aes_round_ctrl #(.NUM_ROUNDS(10), .ROUND_CYCLES(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start_valid(sv_b), .start_ready(sr_b),
        .abort(abort), .dp_stall(dp_stall), .kld(kl_b), .rcon_en(rc_b),
        .round(rd_b), .first_round(fr_b), .last_round(lr_b),
        .busy(bs_b), .done(dn_b)
    );

    logic       m_sr, m_kl, m_rc, m_fr, m_lr, m_bs, m_dn;
    logic [3:0] m_rd;
    assign m_sr = (sel == 1) ? sr_b : sr_a;
    assign m_kl = (sel == 1) ? kl_b : kl_a;
    assign m_rc = (sel == 1) ? rc_b : rc_a;
    assign m_fr = (sel == 1) ? fr_b : fr_a;
    assign m_lr = (sel == 1) ? lr_b : lr_a;
    assign m_bs = (sel == 1) ? bs_b : bs_a;
    assign m_dn = (sel == 1) ? dn_b : dn_a;
    assign m_rd = (sel == 1) ? rd_b : rd_a;

    typedef struct {
        int sel;
        int stall_at;
        int stall_len;
        int abort_at;
        int exp_kld;
        int exp_done;
        int exp_n;
        int exp_first;
        int exp_last;
        int exp_rc;
    } vec_t;

    vec_t vecs[10];

    int n_cmp = 0;
    int n_bad = 0;
    int cnt = 0;
    int q_kld[$];
    int q_done[$];
    int rc_n, rc_first, rc_last;
    logic [7:0] rc_model = 8'h00;

    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d",
                     nm, cnt, act, exp);
        end
    endtask

    // Sample at negedge and feed the scoreboard with observed events.
    task automatic samp();
        @(negedge clk);
        if (m_kl) begin
            if (q_kld.size() == 0) chk("kld_unexpected", cnt, -1);
            else chk("kld_cycle", cnt, q_kld.pop_front());
            rc_model = 8'h01;
        end
        if (m_rc) begin
            if (dp_stall) chk("rcon_while_stall", 1, 0);
            if (rc_n == 0) rc_first = cnt;
            rc_last = cnt;
            rc_n++;
            rc_model = xt(rc_model);
        end
        if (m_dn) begin
            if (q_done.size() == 0) chk("done_unexpected", cnt, -1);
            else chk("done_cycle", cnt, q_done.pop_front());
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cnt++;
    endtask

    task automatic run(input vec_t v, input int idx);
        int t0;
        string s;
        s = $sformatf("v%0d", idx);
        sel = v.sel;
        t0 = cnt;
        rc_n = 0;
        rc_first = -1;
        rc_last = -1;
        if (v.exp_kld != 0) q_kld.push_back(t0 + 1);
        if (v.exp_done >= 0) q_done.push_back(t0 + v.exp_done);
        for (int i = 0; i < 45; i++) begin
            start_valid = (i == 0);
            abort = (i == v.abort_at);
            dp_stall = (v.stall_at >= 0) && (i >= v.stall_at)
                       && (i < v.stall_at + v.stall_len);
            samp();
            if (v.abort_at >= 0 && i == v.abort_at + 1) begin
                chk({s, "_abort_busy"}, int'(m_bs), 0);
                chk({s, "_abort_round"}, int'(m_rd), 0);
            end
            adv();
        end
        start_valid = 1'b0;
        abort = 1'b0;
        dp_stall = 1'b0;
        chk({s, "_kld_missing"}, q_kld.size(), 0);
        chk({s, "_done_missing"}, q_done.size(), 0);
        q_kld.delete();
        q_done.delete();
        chk({s, "_rcon_count"}, rc_n, v.exp_n);
        chk({s, "_rcon_first"}, (rc_n > 0) ? rc_first - t0 : -1, v.exp_first);
        chk({s, "_rcon_last"}, (rc_n > 0) ? rc_last - t0 : -1, v.exp_last);
        if (v.exp_rc >= 0) chk({s, "_rcon_value"}, int'(rc_model), v.exp_rc);
        chk({s, "_idle_ready"}, int'(m_sr), 1);
    endtask

    initial begin
        vecs[0] = '{0, -1, 0, -1, 1, 12, 9, 2, 10, 'h36};
        vecs[1] = '{1, -1, 0, -1, 1, 32, 9, 4, 28, 'h36};
        vecs[2] = '{0,  6, 4, -1, 1, 16, 9, 2, 14, 'h36};
        vecs[3] = '{1,  5, 2, -1, 1, 34, 9, 4, 30, 'h36};
        vecs[4] = '{0,  1, 1, -1, 1, 12, 9, 2, 10, 'h36};
        vecs[5] = '{0, 12, 1, -1, 1, 12, 9, 2, 10, 'h36};
        vecs[6] = '{0, -1, 0,  7, 1, -1, 5, 2,  6, 'h20};
        vecs[7] = '{0, -1, 0,  1, 0, -1, 0, -1, -1, -1};
        vecs[8] = '{0, -1, 0, 12, 1, -1, 9, 2, 10, 'h36};
        vecs[9] = '{1,  4, 1, -1, 1, 33, 9, 5, 29, 'h36};

        // reset values, both instances
        #2;
        chk("rst_ready_a", int'(sr_a), 1);
        chk("rst_busy_a", int'(bs_a), 0);
        chk("rst_pulses_a", int'({kl_a, rc_a, dn_a}), 0);
        chk("rst_round_a", int'(rd_a), 0);
        chk("rst_ready_b", int'(sr_b), 1);
        chk("rst_round_b", int'(rd_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        adv();
        adv();

        foreach (vecs[k]) run(vecs[k], k);

        // round/flag walk with start_valid held high: exactly one handshake
        begin
            int t0;
            sel = 0;
            t0 = cnt;
            q_kld.push_back(t0 + 1);
            q_done.push_back(t0 + 12);
            for (int i = 0; i < 14; i++) begin
                start_valid = (i < 13);
                samp();
                if (i == 0) chk("walk_ready0", int'(m_sr), 1);
                if (i == 1) begin
                    chk("walk_load_round", int'(m_rd), 0);
                    chk("walk_load_busy", int'(m_bs), 1);
                    chk("walk_load_ready", int'(m_sr), 0);
                end
                if (i >= 2 && i <= 11) begin
                    chk("walk_round", int'(m_rd), i - 1);
                    chk("walk_first", int'(m_fr), int'(i == 2));
                    chk("walk_last", int'(m_lr), int'(i == 11));
                    chk("walk_ready", int'(m_sr), 0);
                end
                if (i == 12) begin
                    chk("walk_done_round", int'(m_rd), 10);
                    chk("walk_done_ready", int'(m_sr), 0);
                    chk("walk_done_busy", int'(m_bs), 1);
                end
                if (i == 13) begin
                    chk("walk_end_ready", int'(m_sr), 1);
                    chk("walk_end_busy", int'(m_bs), 0);
                end
                adv();
            end
            chk("walk_kld_missing", q_kld.size(), 0);
            chk("walk_done_missing", q_done.size(), 0);
            q_kld.delete();
            q_done.delete();
        end

        // abort together with start in IDLE: no handshake
        start_valid = 1'b1;
        abort = 1'b1;
        samp();
        chk("abort_start_ready", int'(m_sr), 0);
        adv();
        start_valid = 1'b0;
        abort = 1'b0;
        samp();
        chk("abort_start_busy", int'(m_bs), 0);
        adv();

        // async reset in round 3
        begin
            int t0;
            sel = 0;
            t0 = cnt;
            q_kld.push_back(t0 + 1);
            for (int i = 0; i < 5; i++) begin
                start_valid = (i == 0);
                samp();
                if (i == 4) chk("pre_rst_round", int'(m_rd), 3);
                adv();
            end
            #2;
            rst_n = 1'b0;
            #1;
            chk("rst_mid_busy", int'(m_bs), 0);
            chk("rst_mid_round", int'(m_rd), 0);
            chk("rst_mid_ready", int'(m_sr), 1);
            chk("rst_mid_pulses", int'({m_kl, m_rc, m_dn}), 0);
            q_kld.delete();
            q_done.delete();
            @(negedge clk);
            rst_n = 1'b1;
            adv();
            for (int i = 0; i < 6; i++) begin
                samp();
                chk("post_rst_ready", int'(m_sr), 1);
                chk("post_rst_pulses", int'({m_kl, m_rc, m_dn}), 0);
                adv();
            end
        end

        // fresh block after abort and reset still runs to completion
        run(vecs[0], 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
